// File: rtl/case_sel_encoder.sv
// Inverse of the 3-bit-select case decoder: scans sel 0..7 one per cycle and
// reports the lowest sel whose decoded value equals the target byte.
module case_sel_encoder #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_target,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_found,
    output logic [2:0] out_sel,
    output logic [3:0] out_count,
    output logic       busy
);

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 3;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   target_q;
    logic [DW-1:0]   data_q;
    logic [SW-1:0]   idx;
    logic [SW-1:0]   first_sel;
    logic            first_found;
    logic [CW-1:0]   count;

    logic [DW-1:0]   dec;
    logic            match;
    logic            last;
    logic [CW-1:0]   count_nxt;

    // Decoder function evaluated against the captured operands at the current index.
    always_comb begin
        dec = '0;
        case (idx)
            3'd0:    dec = 8'h00;
            3'd1:    dec = 8'hAA;
            3'd2:    dec = 8'h55;
            3'd3:    dec = data_q;
            3'd4:    dec = ~data_q;
            3'd5:    dec = DW'(data_q + 8'h01);
            default: dec = 8'hFF;
        endcase
        match     = (dec == target_q);
        count_nxt = CW'(count + CW'(match));
        last      = (EARLY_EXIT && match) || (idx == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            target_q    <= '0;
            data_q      <= '0;
            idx         <= '0;
            first_sel   <= '0;
            first_found <= 1'b0;
            count       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_found   <= 1'b0;
            out_sel     <= '0;
            out_count   <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state       <= SEARCH;
                        target_q    <= in_target;
                        data_q      <= in_data;
                        idx         <= '0;
                        first_sel   <= '0;
                        first_found <= 1'b0;
                        count       <= '0;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        out_found   <= 1'b0;
                        out_sel     <= '0;
                        out_count   <= '0;
                    end
                end
                SEARCH: begin
                    count <= count_nxt;
                    if (match && !first_found) begin
                        first_sel   <= idx;
                        first_found <= 1'b1;
                    end
                    if (last) begin
                        // Fold this cycle's match into the result registers directly.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_found <= first_found | match;
                        out_sel   <= first_found ? first_sel : (match ? idx : 3'd0);
                        out_count <= count_nxt;
                    end else begin
                        idx <= SW'(idx + 3'd1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
